// File: rtl/mac_pipe_vec.sv
// Multi-lane signed dot-product multiply-accumulate with optional saturation.
// Latency: operands presented before edge k reach out/out_valid after edge k+MULT_STAGES.
// Backpressure: none; every stage advances every cycle, one sample per cycle.
module mac_pipe_vec #(
  parameter int INW         = 16,
  parameter int OUTW        = 64,
  parameter int LANES       = 4,
  parameter int MULT_STAGES = 1,
  parameter int SAT         = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*INW-1:0]   input0,
  input  logic [LANES*INW-1:0]   input1,
  input  logic [LANES-1:0]       lane_mask,
  input  logic [OUTW-1:0]        init_value,
  input  logic                   init_acc,
  input  logic                   input_valid,
  output logic [OUTW-1:0]        out,
  output logic                   out_valid,
  output logic                   overflow
);

  localparam int PW = 2 * INW;
  localparam int DW = PW + $clog2(LANES);

  // Full-precision signed lane product; operands are sign-extended first so
  // the truncated PW-bit result is exact.
  function automatic logic signed [PW-1:0] lane_prod(input logic signed [INW-1:0] a,
                                                      input logic signed [INW-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  logic signed [DW-1:0] dot_c;

  // Masked lane products summed into the sign-extended dot product.
  always_comb begin
    dot_c = '0;
    for (int l = 0; l < LANES; l++) begin
      if (lane_mask[l]) begin
        dot_c = dot_c + DW'(lane_prod(input0[l*INW +: INW], input1[l*INW +: INW]));
      end
    end
  end

  // Pipeline registers: dot, valid, init request and init value travel together
  // so a preload stays ordered against samples already in flight.
  logic signed [DW-1:0] dot_q  [MULT_STAGES];
  logic signed [DW-1:0] dot_d  [MULT_STAGES];
  logic                 vld_q  [MULT_STAGES];
  logic                 vld_d  [MULT_STAGES];
  logic                 init_q [MULT_STAGES];
  logic                 init_d [MULT_STAGES];
  logic [OUTW-1:0]      ival_q [MULT_STAGES];
  logic [OUTW-1:0]      ival_d [MULT_STAGES];

  // Shift the pipeline by one stage each cycle.
  always_comb begin
    dot_d[0]  = dot_c;
    vld_d[0]  = input_valid;
    init_d[0] = init_acc;
    ival_d[0] = init_value;
    for (int s = 1; s < MULT_STAGES; s++) begin
      dot_d[s]  = dot_q[s-1];
      vld_d[s]  = vld_q[s-1];
      init_d[s] = init_q[s-1];
      ival_d[s] = ival_q[s-1];
    end
  end

  // Pipeline state; reset discards every in-flight sample and preload.
  always_ff @(posedge clk) begin
    for (int s = 0; s < MULT_STAGES; s++) begin
      if (reset) begin
        dot_q[s]  <= '0;
        vld_q[s]  <= 1'b0;
        init_q[s] <= 1'b0;
        ival_q[s] <= '0;
      end else begin
        dot_q[s]  <= dot_d[s];
        vld_q[s]  <= vld_d[s];
        init_q[s] <= init_d[s];
        ival_q[s] <= ival_d[s];
      end
    end
  end

  // Last-stage view of the pipeline as seen by the accumulator.
  logic signed [DW-1:0] last_dot;
  logic                 last_vld;
  logic                 last_init;
  logic [OUTW-1:0]      last_ival;

  assign last_dot  = dot_q[MULT_STAGES-1];
  assign last_vld  = vld_q[MULT_STAGES-1];
  assign last_init = init_q[MULT_STAGES-1];
  assign last_ival = ival_q[MULT_STAGES-1];

  logic [OUTW-1:0]     acc_q, acc_d;
  logic                out_vld_q, out_vld_d;
  logic                ovf_q, ovf_d;
  logic signed [OUTW:0] base_x;
  logic signed [OUTW:0] sum_x;
  logic                add_ovf;
  logic [OUTW-1:0]     add_res;

  // One-bit-wider add; a preload in the same cycle replaces the old
  // accumulator as the addend base.
  always_comb begin
    base_x  = last_init ? (OUTW+1)'(signed'(last_ival)) : (OUTW+1)'(signed'(acc_q));
    sum_x   = base_x + (OUTW+1)'(last_dot);
    add_ovf = sum_x[OUTW] ^ sum_x[OUTW-1];
    if ((SAT != 0) && add_ovf) begin
      add_res = sum_x[OUTW] ? {1'b1, {(OUTW-1){1'b0}}} : {1'b0, {(OUTW-1){1'b1}}};
    end else begin
      add_res = sum_x[OUTW-1:0];
    end
  end

  // Accumulator next state: init+valid, init only, valid only, or hold.
  always_comb begin
    acc_d     = acc_q;
    out_vld_d = 1'b0;
    ovf_d     = ovf_q;
    case ({last_init, last_vld})
      2'b11: begin
        acc_d     = add_res;
        out_vld_d = 1'b1;
        ovf_d     = add_ovf;
      end
      2'b10: begin
        acc_d = last_ival;
        ovf_d = 1'b0;
      end
      2'b01: begin
        acc_d     = add_res;
        out_vld_d = 1'b1;
        ovf_d     = ovf_q | add_ovf;
      end
      default: ;
    endcase
  end

  // Accumulator, valid pulse and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      out_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      out_vld_q <= out_vld_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out       = acc_q;
  assign out_valid = out_vld_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_mac_pipe_vec.sv
// Directed bench for mac_pipe_vec across several parameter sets.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: not applicable; stimulus is a fixed cycle-by-cycle sequence.
module tb_mac_pipe_vec;

  logic         clk;
  logic         reset;
  logic [63:0]  input0;
  logic [63:0]  input1;
  logic [3:0]   lane_mask;
  logic [63:0]  init_value;
  logic         init_acc;
  logic         input_valid;

  logic [63:0]  out1, out2, out3;
  logic         vld1, vld2, vld3;
  logic         ovf1, ovf2, ovf3;
  logic [33:0]  outs, outw;
  logic         vlds, vldw;
  logic         ovfs, ovfw;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] OPA  = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] OPB  = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [63:0] NEGA = {16'd4, 16'd3, 16'd2, 16'hFFFD};
  localparam logic [63:0] NEGB = {16'd8, 16'd7, 16'd6, 16'd7};
  localparam logic [63:0] MAX34 = 64'h1_FFFF_FFFF;

  mac_pipe_vec #(.INW(16), .OUTW(64), .LANES(4), .MULT_STAGES(1), .SAT(0)) u1 (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1), .lane_mask(lane_mask),
    .init_value(init_value), .init_acc(init_acc), .input_valid(input_valid),
    .out(out1), .out_valid(vld1), .overflow(ovf1));

  mac_pipe_vec #(.INW(16), .OUTW(64), .LANES(4), .MULT_STAGES(2), .SAT(0)) u2 (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1), .lane_mask(lane_mask),
    .init_value(init_value), .init_acc(init_acc), .input_valid(input_valid),
    .out(out2), .out_valid(vld2), .overflow(ovf2));

  mac_pipe_vec #(.INW(16), .OUTW(64), .LANES(4), .MULT_STAGES(3), .SAT(0)) u3 (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1), .lane_mask(lane_mask),
    .init_value(init_value), .init_acc(init_acc), .input_valid(input_valid),
    .out(out3), .out_valid(vld3), .overflow(ovf3));

  mac_pipe_vec #(.INW(16), .OUTW(34), .LANES(4), .MULT_STAGES(1), .SAT(1)) us (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1), .lane_mask(lane_mask),
    .init_value(init_value[33:0]), .init_acc(init_acc), .input_valid(input_valid),
    .out(outs), .out_valid(vlds), .overflow(ovfs));

  mac_pipe_vec #(.INW(16), .OUTW(34), .LANES(4), .MULT_STAGES(1), .SAT(0)) uw (
    .clk(clk), .reset(reset), .input0(input0), .input1(input1), .lane_mask(lane_mask),
    .init_value(init_value[33:0]), .init_acc(init_acc), .input_valid(input_valid),
    .out(outw), .out_valid(vldw), .overflow(ovfw));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    input_valid = 1'b0;
    init_acc    = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; input0 = OPA; input1 = OPB; lane_mask = 4'hF;
    init_value = '0; init_acc = 1'b0; input_valid = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_out", out1, 64'd0);
    chk("rst_vld", {63'd0, vld1}, 64'd0);
    chk("rst_ovf", {63'd0, ovf1}, 64'd0);
    reset = 1'b0;

    // Preload 10, then two samples of dot 70
    init_acc = 1'b1; init_value = 64'd10;
    tick();
    init_acc = 1'b0; input_valid = 1'b1;
    tick();
    chk("pre_out", out1, 64'd10);
    chk("pre_vld", {63'd0, vld1}, 64'd0);
    tick();
    chk("acc1_out", out1, 64'd80);
    chk("acc1_vld", {63'd0, vld1}, 64'd1);
    input_valid = 1'b0;
    tick();
    chk("acc2_out", out1, 64'd150);
    chk("acc2_vld", {63'd0, vld1}, 64'd1);
    tick();
    chk("hold_out", out1, 64'd150);
    chk("hold_vld", {63'd0, vld1}, 64'd0);

    // Masking: init 0 with sample (26), another 26, then -21 on lane 0 only
    init_acc = 1'b1; init_value = 64'd0; input_valid = 1'b1; lane_mask = 4'b0101;
    tick();
    init_acc = 1'b0;
    tick();
    chk("mask1_out", out1, 64'd26);
    input0 = NEGA; input1 = NEGB; lane_mask = 4'b0001;
    tick();
    chk("mask2_out", out1, 64'd52);
    input_valid = 1'b0;
    tick();
    chk("neg_out", out1, 64'd31);
    chk("neg_ovf", {63'd0, ovf1}, 64'd0);

    // Three-stage latency
    input0 = OPA; input1 = OPB; lane_mask = 4'hF;
    do_reset();
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    chk("ms3_e0", out3, 64'd0);
    tick();
    chk("ms3_e1", out3, 64'd0);
    tick();
    chk("ms3_e2_out", out3, 64'd0);
    chk("ms3_e2_vld", {63'd0, vld3}, 64'd0);
    tick();
    chk("ms3_e3_out", out3, 64'd70);
    chk("ms3_e3_vld", {63'd0, vld3}, 64'd1);
    // Combined init + valid lands on the preload, not the old value
    init_acc = 1'b1; init_value = 64'd100; input_valid = 1'b1; lane_mask = 4'b0101;
    tick();
    idle();
    tick(); tick();
    chk("ms3_pend", out3, 64'd70);
    tick();
    chk("ms3_init_out", out3, 64'd126);
    chk("ms3_init_ovf", {63'd0, ovf3}, 64'd0);

    // Saturation vs wrap at OUTW=34
    lane_mask = 4'hF;
    do_reset();
    init_acc = 1'b1; init_value = MAX34;
    tick();
    init_acc = 1'b0; input_valid = 1'b1;
    tick();
    chk("sat_pre_out", {30'd0, outs}, MAX34);
    chk("sat_pre_ovf", {63'd0, ovfs}, 64'd0);
    input0 = NEGA; input1 = NEGB; lane_mask = 4'b0001;
    tick();
    chk("sat_clamp", {30'd0, outs}, MAX34);
    chk("sat_ovf", {63'd0, ovfs}, 64'd1);
    chk("wrap_out", {30'd0, outw}, 64'h2_0000_0045);
    chk("wrap_ovf", {63'd0, ovfw}, 64'd1);
    input_valid = 1'b0;
    tick();
    chk("sat_sub_out", {30'd0, outs}, 64'h1_FFFF_FFEA);
    chk("sat_sticky", {63'd0, ovfs}, 64'd1);
    chk("wrap_sticky", {63'd0, ovfw}, 64'd1);
    init_acc = 1'b1; init_value = 64'd5;
    tick();
    init_acc = 1'b0;
    tick();
    chk("sat_reinit_out", {30'd0, outs}, 64'd5);
    chk("sat_reinit_ovf", {63'd0, ovfs}, 64'd0);
    chk("wrap_reinit_ovf", {63'd0, ovfw}, 64'd0);
    chk("sat_reinit_vld", {63'd0, vlds}, 64'd0);
    chk("wrap_reinit_vld", {63'd0, vldw}, 64'd0);

    // Reset mid-stream with two-stage pipeline
    input0 = OPA; input1 = OPB; lane_mask = 4'hF;
    do_reset();
    input_valid = 1'b1;
    tick(); tick(); tick();
    chk("ms2_first", out2, 64'd70);
    chk("ms2_first_vld", {63'd0, vld2}, 64'd1);
    input_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ms2_rst_out", out2, 64'd0);
    chk("ms2_rst_vld", {63'd0, vld2}, 64'd0);
    chk("ms2_rst_ovf", {63'd0, ovf2}, 64'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("ms2_no_stale_out", out2, 64'd0);
      chk("ms2_no_stale_vld", {63'd0, vld2}, 64'd0);
    end

    // Gaps: valid, idle, init-only, valid, idle
    do_reset();
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
    tick();
    chk("gap_v1_out", out1, 64'd70);
    chk("gap_v1_vld", {63'd0, vld1}, 64'd1);
    init_acc = 1'b1; init_value = 64'd1000;
    tick();
    chk("gap_hold_out", out1, 64'd70);
    chk("gap_hold_vld", {63'd0, vld1}, 64'd0);
    init_acc = 1'b0; input_valid = 1'b1;
    tick();
    chk("gap_init_out", out1, 64'd1000);
    chk("gap_init_vld", {63'd0, vld1}, 64'd0);
    input_valid = 1'b0;
    tick();
    chk("gap_v2_out", out1, 64'd1070);
    chk("gap_v2_vld", {63'd0, vld1}, 64'd1);
    tick();
    chk("gap_end_out", out1, 64'd1070);
    chk("gap_end_vld", {63'd0, vld1}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mac_pipe_vec.md
# mac_pipe_vec

Parametrised, multi-lane pipelined multiply-accumulate unit. It is the next-generation MAC for the 2D-convolution datapath. Each valid cycle it computes a LANES-wide signed dot product of two operand vectors, with per-lane masking. The product passes through a configurable number of register stages, and the accumulator applies optional saturation, with init, valid and overflow tracking kept cycle-aligned through the pipeline.

## Interface
Parameters:
- INW, 16: signed operand width per lane.
- OUTW, 64: accumulator/output width. Must satisfy OUTW ≥ 2*INW + $clog2(LANES).
- LANES, 4: number of parallel multiplier lanes (≥1).
- MULT_STAGES, 1: register stages between multipliers and accumulator (≥1).
- SAT, 0: 0 = two's-complement wrap; 1 = clamp to signed OUTW limits.

Ports (reset reset, synchronous, active-high; clock clk):
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous active-high reset.
- input0, input, LANES*INW: lane i = bits [i*INW +: INW], signed.
- input1, input, LANES*INW: lane i = bits [i*INW +: INW], signed.
- lane_mask, input, LANES: 1 = lane contributes; 0 = lane product forced to 0.
- init_value, input, OUTW: signed accumulator preload value.
- init_acc, input, 1: preload request, pipelined with the data.
- input_valid, input, 1: the operands this cycle are valid.
- out, output, OUTW: signed accumulator value.
- out_valid, output, 1: one-cycle pulse when the accumulator absorbed a valid sample.
- overflow, output, 1: sticky overflow flag.

## Operation
- Stage 0 (combinational): p_i = input0_i * input1_i for each lane, 2*INW bits signed; p_i = 0 where lane_mask[i] = 0. dot = sign-extended sum of the p_i, 2*INW + $clog2(LANES) bits, computed before the first register.
- Pipeline: dot, input_valid, init_acc and init_value advance together through MULT_STAGES register stages (v_d, i_d, iv_d at the last stage). Every stage advances every cycle; there is no stall.
- Accumulator update, priority order:
  - reset: out = 0, out_valid = 0, overflow = 0, all pipeline stages cleared (valid/init flags = 0, data = 0).
  - i_d & v_d: out ← sat(iv_d + dot_d); out_valid = 1. overflow is cleared, then set if this add overflows.
  - i_d & !v_d: out ← iv_d; out_valid = 0; overflow ← 0.
  - !i_d & v_d: out ← sat(out + dot_d); out_valid = 1; overflow ← overflow | ovf.
  - otherwise: out holds; out_valid = 0.
- Arithmetic: the add is computed at OUTW+1 bits. ovf = the two top bits differ.
  - SAT = 0: out takes the low OUTW bits (wrap).
  - SAT = 1: positive ovf gives 2^(OUTW-1)-1; negative ovf gives -2^(OUTW-1).
  - overflow is flagged in both modes.
- init_acc with input_valid low still travels the pipeline, so preloads are ordered correctly relative to in-flight samples.

## Timing
- Latency: a sample presented before edge k affects out and out_valid after edge k+MULT_STAGES.
- With MULT_STAGES=1: inputs captured at edge k, accumulated at edge k+1. This matches the existing MAC timing.
- Throughput: one sample per cycle. Back-to-back valids accumulate without bubbles.
- init_acc asserted in the same cycle as a valid sample: that sample is added onto init_value, not onto the old out.
- Reset asserted mid-stream: in-flight samples are discarded. The first post-reset valid sample appears MULT_STAGES+1 edges after it is presented.
- Outputs are registered; there is no combinational input-to-output path.

## Test plan
1. LANES=4, MULT_STAGES=1, all mask bits set. Preload init_value=10 with init_acc, then valid input0={1,2,3,4}, input1={5,6,7,8} for 2 cycles -> out = 10, then 80, then 150. out_valid high exactly on the two update cycles.
2. Masking: same operands, lane_mask=4'b0101 -> each sample adds 1*5 + 3*7 = 26. Check with negative operands {-3} × {7} on lane 0 -> contributes -21.
3. MULT_STAGES=3: a single valid pulse at cycle 0 -> out changes only after edge 3. Combined init_acc+valid (init 100, dot 26) -> out = 126, not old out + 26.
4. Saturation: OUTW=2*INW+2, SAT=1. Preload max positive and add a positive dot -> out clamps to 2^(OUTW-1)-1 and overflow = 1; it stays set until the next init. SAT=0 with the same stimulus -> wrapped value and overflow = 1.
5. Reset mid-stream: 3 valid samples in flight with MULT_STAGES=2, assert reset for 1 cycle -> out = 0, out_valid = 0, overflow = 0. No stale sample is accumulated afterwards.
6. Gaps: valid 1-0-1 pattern with an init_acc-only cycle between -> out holds during gaps, and the init takes effect in arrival order.
